// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, data LSB first, STOP_BITS stop bits, registered line output.
// Define UART_TX_PARITY_EN to insert a parity bit after bit 7 (sense chosen by PARITY_ODD).
module uart_tx #(
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [19:0] BpsNum,
   input  logic        TxValid,
   input  logic [7:0]  TxData,
   output logic        TxReady,
   output logic        UartTx,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
      $error("uart_tx: PARITY_ODD must be 0 or 1");
   end

   localparam logic LAST_STOP = (STOP_BITS == 2);
`ifdef UART_TX_PARITY_EN
   localparam logic PODD = (PARITY_ODD != 0);
`endif

   state_t      state_q, state_d;
   logic [19:0] cnt_q, cnt_d;
   logic [19:0] bps_q, bps_d;
   logic [2:0]  bit_q, bit_d;
   logic        stop_q, stop_d;
   logic [7:0]  data_q, data_d;
   logic        tx_q, tx_d;
   logic        bit_end;
   logic [2:0]  nxt_bit;

   assign bit_end = (cnt_q == bps_q - 20'd1);
   assign nxt_bit = bit_q + 3'd1;
   assign TxReady = (state_q == IDLE);
   assign UartTx  = tx_q;

   // tx_d is chosen for the state being entered, so the line register switches with the state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bps_d   = bps_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      data_d  = data_q;
      tx_d    = tx_q;
      done    = 1'b0;
      if (state_q != IDLE) begin
         cnt_d = bit_end ? 20'd0 : cnt_q + 20'd1;
      end
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (TxValid) begin
               state_d = START;
               data_d  = TxData;
               bps_d   = (BpsNum < 20'd2) ? 20'd2 : BpsNum;
               cnt_d   = 20'd0;
               bit_d   = 3'd0;
               stop_d  = 1'b0;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = data_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               bit_d = nxt_bit;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = (^data_q) ^ PODD;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  tx_d = data_q[nxt_bit];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (stop_q == LAST_STOP) begin
                  state_d = IDLE;
                  done    = 1'b1;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
               tx_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= 20'd0;
         bps_q   <= 20'd0;
         bit_q   <= 3'd0;
         stop_q  <= 1'b0;
         data_q  <= 8'd0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bps_q   <= bps_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 stop/even, 2 stop/odd) share stimulus and are checked
// every cycle against a frame-level model, plus directed literal expectations.
module tb_uart_tx;

   logic        clk = 1'b0;
   logic        rstn;
   logic [19:0] BpsNum;
   logic        TxValid;
   logic [7:0]  TxData;
   logic        rdy_a, tx_a, done_a;
   logic        rdy_b, tx_b, done_b;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   uart_tx #(.STOP_BITS(1), .PARITY_ODD(0)) dut_a (
      .clk(clk), .rstn(rstn), .BpsNum(BpsNum), .TxValid(TxValid), .TxData(TxData),
      .TxReady(rdy_a), .UartTx(tx_a), .done(done_a));

   uart_tx #(.STOP_BITS(2), .PARITY_ODD(1)) dut_b (
      .clk(clk), .rstn(rstn), .BpsNum(BpsNum), .TxValid(TxValid), .TxData(TxData),
      .TxReady(rdy_b), .UartTx(tx_b), .done(done_b));

`ifdef UART_TX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   localparam int FA = 9 + PBITS + 1;
   localparam int FB = 9 + PBITS + 2;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event never seen, gave up at cycle %0d", name, cyc);
   endtask

   // Frame-level model: a frame is a bit list held for bps cycles each, starting the cycle after accept.
   bit          mvalid = 1'b0;
   bit          mbusy [2];
   int          mt0   [2];
   int          mbps  [2];
   int          mlen  [2];
   logic [11:0] mbits [2];
   logic        etx   [2];
   logic        edone [2];
   logic        erdy  [2];
   int          moff;

   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (!rstn) begin
            mbusy[k] = 1'b0;
         end else if (mbusy[k]) begin
            if (cyc - 1 == mt0[k] + mlen[k] * mbps[k] - 1) mbusy[k] = 1'b0;
         end else if (TxValid) begin
            mbusy[k]         = 1'b1;
            mt0[k]           = cyc;
            mbps[k]          = (BpsNum < 20'd2) ? 2 : int'(BpsNum);
            mbits[k]         = '1;
            mbits[k][0]      = 1'b0;
            mbits[k][8:1]    = TxData;
`ifdef UART_TX_PARITY_EN
            mbits[k][9]      = (^TxData) ^ (k == 1);
`endif
            mlen[k]          = 9 + PBITS + 1 + k;
         end
         if (mbusy[k]) begin
            moff     = cyc - mt0[k];
            etx[k]   = mbits[k][moff / mbps[k]];
            edone[k] = (moff == mlen[k] * mbps[k] - 1);
            erdy[k]  = 1'b0;
         end else begin
            etx[k]   = 1'b1;
            edone[k] = 1'b0;
            erdy[k]  = 1'b1;
         end
      end
      if (!rstn) mvalid = 1'b1;
   end

   always @(negedge clk) begin
      if (mvalid) begin
         check("model_tx_a",   tx_a,   etx[0]);
         check("model_done_a", done_a, edone[0]);
         check("model_rdy_a",  rdy_a,  erdy[0]);
         check("model_tx_b",   tx_b,   etx[1]);
         check("model_done_b", done_b, edone[1]);
         check("model_rdy_b",  rdy_b,  erdy[1]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic [19:0] b);
      TxData  = d;
      BpsNum  = b;
      TxValid = 1'b1;
      step();
      TxValid = 1'b0;
   endtask

   task automatic wait_done(input int k, output int c);
      c = -1;
      for (int i = 0; i < 20000 && c < 0; i++) begin
         @(negedge clk);
         if ((k == 0 ? done_a : done_b) == 1'b1) c = cyc;
      end
      if (c < 0) timeout(k == 0 ? "wait_done_a" : "wait_done_b");
   endtask

   task automatic goto_cycle(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   int         l, d, d1, l2, nda, ndb, nd;
   logic [8:0] pat;

   initial begin
      rstn    = 1'b0;
      TxValid = 1'b1;
      TxData  = 8'hFF;
      BpsNum  = 20'd5;
      step(); step(); step();
      @(negedge clk);
      check("reset_tx",   tx_a,   1);
      check("reset_rdy",  rdy_a,  1);
      check("reset_done", done_a, 0);
      @(posedge clk); #1;
      rstn    = 1'b1;
      TxValid = 1'b0;
      step();

      // Test 1: 0x55 at 434 cycles/bit
      TxData  = 8'h55;
      BpsNum  = 20'd434;
      TxValid = 1'b1;
      @(negedge clk);
      check("t1_accept_rdy", rdy_a, 1);
      check("t1_accept_tx",  tx_a,  1);
      step();
      TxValid = 1'b0;
      @(negedge clk);
      check("t1_latency_tx", tx_a, 0);
      l   = cyc;
      pat = 9'b010101010;
      for (int i = 0; i < 9; i++) begin
         goto_cycle(l + i * 434 + 217);
         check("t1_bit", tx_a, pat[i]);
      end
      goto_cycle(l + 9 * 434 + 217);
      check("t1_bit9", tx_a, (PBITS == 1) ? 0 : 1);
      wait_done(0, d);
      check("t1_done_cycle", d - l, FA * 434 - 1);
      wait_done(1, d);
      step(); step();

      // Test 2: TxValid held high, 0xA3 then 0x0F
      BpsNum  = 20'd20;
      TxData  = 8'hA3;
      TxValid = 1'b1;
      nda = 0; ndb = 0; d1 = -1; l2 = -1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (done_a) begin
            nda++;
            if (d1 < 0) d1 = cyc;
         end
         if (d1 >= 0 && l2 < 0 && tx_a == 1'b0) l2 = cyc;
         if (done_b) ndb++;
         @(posedge clk); #1;
         if (i == 0)   TxData  = 8'h0F;
         if (i == 300) TxValid = 1'b0;
      end
      check("t2_done_count_a", nda, 2);
      check("t2_done_count_b", ndb, 2);
      check("t2_idle_gap",     l2 - d1, 2);

      // Test 3: parity (or stop bit) after data bit 7 for 0x07
      step();
      send(8'h07, 20'd8);
      l = cyc;
      goto_cycle(l + 9 * 8 + 4);
      check("t3_bit9_a", tx_a, 1);
      check("t3_bit9_b", tx_b, (PBITS == 1) ? 0 : 1);
      wait_done(1, d);
      step(); step();

      // Test 4: BpsNum change mid-frame
      send(8'hC4, 20'd434);
      l = cyc;
      while (cyc < l + 100) step();
      BpsNum = 20'd217;
      wait_done(0, d);
      check("t4_frame_keeps_434", d - l, FA * 434 - 1);
      wait_done(1, d);
      step(); step();
      send(8'h3B, 20'd217);
      l = cyc;
      wait_done(0, d);
      check("t4_next_frame_217", d - l, FA * 217 - 1);
      wait_done(1, d);
      step(); step();

      // Test 5: reset during data bit 3
      send(8'h00, 20'd10);
      l = cyc;
      while (cyc < l + 43) step();
      @(negedge clk);
      check("t5_mid_frame_tx", tx_a, 0);
      rstn    = 1'b0;
      TxValid = 1'b1;
      @(posedge clk); #1;
      rstn    = 1'b1;
      TxValid = 1'b0;
      @(negedge clk);
      check("t5_tx_a",  tx_a,  1);
      check("t5_rdy_a", rdy_a, 1);
      check("t5_tx_b",  tx_b,  1);
      check("t5_rdy_b", rdy_b, 1);
      nd = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done_a || done_b) nd++;
      end
      check("t5_no_done", nd, 0);
      step();

      // Test 6: BpsNum=1 clamps to 2-cycle bits, 0xFF
      send(8'hFF, 20'd1);
      l = cyc;
      wait_done(0, d);
      check("t6_frame_a", d - l, FA * 2 - 1);
      wait_done(1, d);
      check("t6_frame_b", d - l, FB * 2 - 1);
      step(); step();

      // Randomized traffic, bit-time changes and occasional resets
      for (int i = 0; i < 4000; i++) begin
         step();
         if ($urandom_range(0, 3) == 0) TxValid = 1'($urandom_range(0, 1));
         TxData = 8'($urandom);
         if ($urandom_range(0, 15) == 0) BpsNum = 20'($urandom_range(0, 12));
         rstn = ($urandom_range(0, 999) != 0);
      end
      rstn    = 1'b1;
      TxValid = 1'b0;
      repeat (300) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter STOP_BITS, default 1, number of stop bits per frame; legal values 1 or 2.
REQ-002 Parameter PARITY_ODD, default 0, parity sense: 0 even, 1 odd; used only when UART_TX_PARITY_EN is defined.
REQ-003 Port clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port rstn  input  1  reset, synchronous, active-low.
REQ-005 Port BpsNum  input  20  clock cycles per bit (e.g. 50000000/115200 = 434).
REQ-006 Port TxValid  input  1  TxData holds a byte to send.
REQ-007 Port TxData  input  8  byte to transmit.
REQ-008 Port TxReady  output  1  block can accept a byte this cycle.
REQ-009 Port UartTx  output  1  serial line; idle high.
REQ-010 Port done  output  1  one-cycle pulse when a frame's last stop bit completes.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL exist only when UART_TX_PARITY_EN is defined.
REQ-012 TxReady SHALL be 1 exactly when state is IDLE.
REQ-013 Accept SHALL occur on a cycle with TxValid=1 and TxReady=1; TxData and BpsNum SHALL be latched on that cycle; later changes to either SHALL not affect the frame in flight.
REQ-014 A latched BpsNum below 2 SHALL be replaced by 2.
REQ-015 On accept, state SHALL go to START; UartTx SHALL go low on the next cycle (latency 1 cycle).
REQ-016 Each bit SHALL drive UartTx for exactly latched-BpsNum cycles, timed by a 20-bit bit counter that counts 0..BpsNum-1 and then wraps to 0.
REQ-017 Order SHALL be: start bit 0; data bits LSB first (bit index 0..7 via a 3-bit counter); optional parity bit; STOP_BITS stop bits of 1.
REQ-018 On the last cycle of the final stop bit, done SHALL pulse 1 and the state SHALL return to IDLE on the next cycle.
REQ-019 UartTx SHALL be 1 in IDLE and SHALL be a registered output that does not glitch between bits.
REQ-020 TxValid while busy SHALL be ignored; no byte SHALL be queued.
REQ-021 With TxValid held at 1, back-to-back frames SHALL be separated by exactly 1 idle-high cycle (the IDLE accept cycle).
REQ-022 done SHALL be 0 on every cycle except the cycle given in REQ-018.

Reset
REQ-023 While rstn=0 at a clock edge: state IDLE, counters 0, UartTx=1, done=0, latched data 0; TxValid SHALL be ignored.
REQ-024 Reset asserted mid-frame SHALL abort the frame; UartTx SHALL be 1 from the next edge; no done SHALL be produced for the aborted frame.
REQ-025 TxReady SHALL read 1 after the first edge with rstn=0.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: when defined, a parity bit SHALL be sent after bit 7 (even parity = XOR of data bits; odd parity = inverted XOR when PARITY_ODD=1) and the frame SHALL be (10+STOP_BITS)*BpsNum cycles long.
REQ-027 When UART_TX_PARITY_EN is not defined, no parity bit or parity logic SHALL exist and the frame SHALL be (9+STOP_BITS)*BpsNum cycles long.

Verification
REQ-028 Test 1: BpsNum=434, send 0x55, no parity -> UartTx pattern 0,1,0,1,0,1,0,1,0,1, each bit 434 cycles; done 4340 cycles after the first low cycle minus 1.
REQ-029 Test 2: TxValid held high with 0xA3 then 0x0F -> two frames, a single idle-high cycle between them, and two done pulses.
REQ-030 Test 3: with UART_TX_PARITY_EN and PARITY_ODD=0, send 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0.
REQ-031 Test 4: BpsNum changes from 434 to 217 mid-frame -> current frame keeps 434-cycle bits; the next frame uses 217.
REQ-032 Test 5: rstn=0 during data bit 3 -> UartTx=1 on the next edge, no done pulse, and TxReady=1.
REQ-033 Test 6: BpsNum=1 and STOP_BITS=2, send 0xFF -> 2-cycle bits; the frame is 22 cycles long, or 24 cycles with parity enabled.
